// File: rtl/wb_regfile.sv
// wb_regfile: general-purpose register file with two combinational read
// ports, one write port fed from writeback, and a separate HI/LO pair.
// Register 0 always reads as zero. A GPR write is forwarded to a read of
// the same address in the same cycle. HI/LO outputs come straight from the
// registers because execute already forwards them.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] r_gpr [NUM_REGS];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              w_gprWrite;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;

    // A GPR write only takes effect outside reset and never to register 0.
    assign w_gprWrite = !rst && we && (waddr != '0);

    // GPR storage: reset clears every entry; entry 0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_gprWrite) begin
            r_gpr[waddr] <= wdata;
        end
    end

    // HI/LO pair updates together on whilo, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (whilo) begin
            r_hi <= hi_i;
            r_lo <= lo_i;
        end
    end

    // Read port 1: zero when disabled, in reset or addressing r0; otherwise bypass a matching write, else storage.
    always_comb begin
        w_rdata1 = '0;
        if (!rst && re1 && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) begin
                w_rdata1 = wdata;
            end else begin
                w_rdata1 = r_gpr[raddr1];
            end
        end
    end

    // Read port 2: same rules as port 1, fully independent of it.
    always_comb begin
        w_rdata2 = '0;
        if (!rst && re2 && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) begin
                w_rdata2 = wdata;
            end else begin
                w_rdata2 = r_gpr[raddr2];
            end
        end
    end

    assign rdata1 = w_rdata1;
    assign rdata2 = w_rdata2;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

endmodule
